// File: rtl/wb_multi_timer.sv
// wb_multi_timer: Wishbone-attached bank of NCH up/down timers.
// Each channel has CTRL (en, down, oneshot, irq_en), COUNT, LIMIT and a
// W1C STATUS flag. Optional macro TIMER_PRESCALER_EN adds a shared
// prescaler (PRESC register in the adr[7]=1 space); without it every
// clock is a tick.
module wb_multi_timer #(
   parameter int NCH  = 4,
   parameter int BITS = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   output logic [NCH*BITS-1:0] count_o,
   output logic                irq_o
);

   logic        ack_reg;
   logic [31:0] dat_reg;
   logic        access;
   logic        bus_wr;
   logic        tick;
   logic [31:0] wr_mask;
   logic [31:0] rd_data;
   logic [31:0] presc_word;
   logic [31:0] rd_word [0:31];
   logic [NCH-1:0] irq_bits;
   logic        unused_adr;

   // An access is accepted only while ack is low, so ack is a single pulse.
   assign access  = wbs_cyc_i & wbs_stb_i & ~ack_reg;
   assign bus_wr  = access & wbs_we_i;
   assign wr_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

   // Bus handshake: ack one cycle after the access, read data latched with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_reg <= 1'b0;
         dat_reg <= '0;
      end else begin
         ack_reg <= access;
         if (access)
            dat_reg <= rd_data;
      end
   end

   assign wbs_ack_o = ack_reg;
   assign wbs_dat_o = dat_reg;

`ifdef TIMER_PRESCALER_EN
   logic [15:0] presc_reg;
   logic [15:0] presc_next;
   logic [15:0] div_reg;
   logic        presc_wr;

   assign presc_wr   = bus_wr & wbs_adr_i[7] & (wbs_adr_i[3:2] == 2'd0);
   assign tick       = (div_reg == presc_reg);
   assign presc_word = (wbs_adr_i[3:2] == 2'd0) ? {16'd0, presc_reg} : 32'd0;

   // Byte-lane merge of a PRESC write.
   always_comb begin
      presc_next = presc_reg;
      if (presc_wr)
         presc_next = (presc_reg & ~wr_mask[15:0]) | (wbs_dat_i[15:0] & wr_mask[15:0]);
   end

   // Free-running divider; a PRESC write restarts the period.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_reg <= '0;
         div_reg   <= '0;
      end else begin
         presc_reg <= presc_next;
         if (presc_wr || tick)
            div_reg <= '0;
         else
            div_reg <= div_reg + 16'd1;
      end
   end
`else
   assign tick       = 1'b1;
   assign presc_word = 32'd0;
`endif

   assign rd_data = wbs_adr_i[7] ? presc_word : rd_word[wbs_adr_i[6:2]];
   assign irq_o   = |irq_bits;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_slot
         if (gi < NCH) begin : g_ch
            logic [3:0]      ctrl_reg, ctrl_next;
            logic [BITS-1:0] count_reg, count_next;
            logic [BITS-1:0] limit_reg, limit_next;
            logic            flag_reg, flag_next;
            logic            match;
            logic            sel_ch, wr_ctrl, wr_count, wr_limit, wr_status;

            assign sel_ch    = bus_wr & ~wbs_adr_i[7] & (wbs_adr_i[6:4] == 3'(gi));
            assign wr_ctrl   = sel_ch & (wbs_adr_i[3:2] == 2'd0);
            assign wr_count  = sel_ch & (wbs_adr_i[3:2] == 2'd1);
            assign wr_limit  = sel_ch & (wbs_adr_i[3:2] == 2'd2);
            assign wr_status = sel_ch & (wbs_adr_i[3:2] == 2'd3);

            // Tick update first; CTRL/COUNT writes then override it, and a match beats W1C.
            always_comb begin
               ctrl_next  = ctrl_reg;
               count_next = count_reg;
               limit_next = limit_reg;
               flag_next  = flag_reg;
               match      = 1'b0;
               if (tick && ctrl_reg[0] && !wr_ctrl && !wr_count) begin
                  if (!ctrl_reg[1]) begin
                     if (count_reg == limit_reg) begin
                        match = 1'b1;
                        if (ctrl_reg[2])
                           ctrl_next[0] = 1'b0;
                        else
                           count_next = '0;
                     end else begin
                        count_next = count_reg + 1'b1;
                     end
                  end else begin
                     if (count_reg == '0) begin
                        match = 1'b1;
                        if (ctrl_reg[2])
                           ctrl_next[0] = 1'b0;
                        else
                           count_next = limit_reg;
                     end else begin
                        count_next = count_reg - 1'b1;
                     end
                  end
               end
               if (wr_ctrl)
                  ctrl_next = (ctrl_reg & ~wr_mask[3:0]) | (wbs_dat_i[3:0] & wr_mask[3:0]);
               if (wr_count)
                  count_next = (count_reg & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
               if (wr_limit)
                  limit_next = (limit_reg & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
               if (match)
                  flag_next = 1'b1;
               else if (wr_status && wbs_sel_i[0] && wbs_dat_i[0])
                  flag_next = 1'b0;
            end

            // Channel state registers.
            always_ff @(posedge clk) begin
               if (reset) begin
                  ctrl_reg  <= '0;
                  count_reg <= '0;
                  limit_reg <= '0;
                  flag_reg  <= 1'b0;
               end else begin
                  ctrl_reg  <= ctrl_next;
                  count_reg <= count_next;
                  limit_reg <= limit_next;
                  flag_reg  <= flag_next;
               end
            end

            assign rd_word[gi*4+0] = {28'd0, ctrl_reg};
            assign rd_word[gi*4+1] = 32'(count_reg);
            assign rd_word[gi*4+2] = 32'(limit_reg);
            assign rd_word[gi*4+3] = {31'd0, flag_reg};
            assign count_o[gi*BITS +: BITS] = count_reg;
            assign irq_bits[gi] = flag_reg & ctrl_reg[3];
         end else begin : g_none
            assign rd_word[gi*4+0] = 32'd0;
            assign rd_word[gi*4+1] = 32'd0;
            assign rd_word[gi*4+2] = 32'd0;
            assign rd_word[gi*4+3] = 32'd0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_wb_multi_timer.sv
// Testbench for wb_multi_timer: scenario tasks with a queue scoreboard of
// expected read data and count sequences.
module tb_wb_multi_timer;
   localparam int NCH  = 4;
   localparam int BITS = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic                cyc, stb, we;
   logic [3:0]          sel;
   logic [31:0]         adr, wdat;
   logic                ack;
   logic [31:0]         rdat;
   logic [NCH*BITS-1:0] count;
   logic                irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   wb_multi_timer #(.NCH(NCH), .BITS(BITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .count_o   (count),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] get_cnt(input int ch);
      return 32'(count[ch*BITS +: BITS]);
   endfunction

   // One bus access; called at #1 after a rising edge, returns at #1 after the ack edge.
   task automatic wb_access(input logic we_in, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit hold,
                            output logic [31:0] rd, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      cyc = 1'b1; stb = 1'b1; we = we_in; adr = a; wdat = d; sel = s;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (ack === 1'b1) got = 1'b1;
      end
      rd = rdat;
      if (!hold) begin
         cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL bus_timeout adr=%h got no ack in %0d cycles, required ack", a, lat);
      end
      $display("bus %s adr=%h wdat=%h sel=%b rdat=%h lat=%0d", we_in ? "WR" : "RD", a, d, s, rd, lat);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      int lat;
      wb_access(1'b1, a, d, s, 1'b0, rd, lat);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
      int lat;
      wb_access(1'b0, a, 32'd0, 4'hF, 1'b0, rd, lat);
   endtask

   task automatic test_reset();
      logic [31:0] rd, e;
      int lat;
      reset = 1'b1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h04; wdat = 32'd0; sel = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ack !== 1'b0 || count !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b irq=%b count=%h, required 0", ack, irq, count);
         end
      end
      reset = 1'b0; cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin
         failures++;
         $display("FAIL reset_abandon ack=%b, required 0", ack);
      end
      exp_q.push_back(32'd0);
      wb_access(1'b0, 32'h04, 32'd0, 4'hF, 1'b1, rd, lat);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL reset_count_read got=%h required=%h", rd, e);
      end
      checks++;
      if (lat !== 1) begin
         failures++;
         $display("FAIL ack_latency got=%0d required=1", lat);
      end
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin
         failures++;
         $display("FAIL ack_width ack=%b one cycle later, required 0", ack);
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_periodic_up();
      logic [31:0] rd, e;
      wb_write(32'h18, 32'd5, 4'hF);
      wb_write(32'h10, 32'h9, 4'hF);
      for (int v = 0; v <= 5; v++) exp_q.push_back(32'(v));
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         e = exp_q.pop_front();
         checks++;
         if (get_cnt(1) !== e) begin
            failures++;
            $display("FAIL periodic_count step %0d got=%h required=%h", i, get_cnt(1), e);
         end
         checks++;
         if (irq !== (i >= 6)) begin
            failures++;
            $display("FAIL periodic_irq step %0d got=%b required=%b", i, irq, (i >= 6));
         end
      end
      exp_q.push_back(32'd1);
      wb_read(32'h1C, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL periodic_flag got=%h required=%h", rd, e);
      end
      wb_write(32'h10, 32'h0, 4'hF);
      wb_write(32'h1C, 32'h1, 4'hF);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_cleared got=%b required=0", irq);
      end
   endtask

   task automatic test_oneshot_down();
      logic [31:0] rd, e;
      wb_write(32'h24, 32'd3, 4'hF);
      wb_write(32'h20, 32'h7, 4'hF);
      exp_q.push_back(32'd3); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         e = exp_q.pop_front();
         checks++;
         if (get_cnt(2) !== e) begin
            failures++;
            $display("FAIL oneshot_count step %0d got=%h required=%h", i, get_cnt(2), e);
         end
      end
      exp_q.push_back(32'h6);
      wb_read(32'h20, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL oneshot_ctrl got=%h required=%h", rd, e);
      end
      exp_q.push_back(32'h1);
      wb_read(32'h2C, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL oneshot_flag got=%h required=%h", rd, e);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, e;
      wb_write(32'h08, 32'hAABBCCDD, 4'b0010);
      exp_q.push_back(32'h0000CC00);
      wb_read(32'h08, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL byte_lane_limit got=%h required=%h", rd, e);
      end
      wb_write(32'h00, 32'hFFFFFFF0, 4'hF);
      exp_q.push_back(32'h0);
      wb_read(32'h00, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL ctrl_unused_bits got=%h required=%h", rd, e);
      end
      wb_write(32'h54, 32'h1234, 4'hF);
      exp_q.push_back(32'h0);
      wb_read(32'h54, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL absent_channel got=%h required=%h", rd, e);
      end
`ifndef TIMER_PRESCALER_EN
      wb_write(32'h80, 32'h5, 4'hF);
      exp_q.push_back(32'h0);
      wb_read(32'h80, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL presc_space_empty got=%h required=%h", rd, e);
      end
`endif
   endtask

   task automatic test_write_priority();
      wb_write(32'h08, 32'h1000, 4'hF);
      wb_write(32'h00, 32'h1, 4'hF);
      repeat (3) begin @(posedge clk); #1; end
      wb_write(32'h04, 32'h100, 4'hF);
      checks++;
      if (get_cnt(0) !== 32'h100) begin
         failures++;
         $display("FAIL count_write_priority got=%h required=%h", get_cnt(0), 32'h100);
      end
      @(posedge clk); #1;
      checks++;
      if (get_cnt(0) !== 32'h101) begin
         failures++;
         $display("FAIL count_after_write got=%h required=%h", get_cnt(0), 32'h101);
      end
      wb_write(32'h00, 32'h0, 4'hF);
   endtask

   task automatic test_w1c_race();
      logic [31:0] rd, e;
      wb_write(32'h38, 32'd7, 4'hF);
      wb_write(32'h30, 32'h1, 4'hF);
      for (int i = 0; i < 40 && get_cnt(3) != 32'd7; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (get_cnt(3) !== 32'd7) begin
         failures++;
         $display("FAIL race_wait count=%h required=%h", get_cnt(3), 32'd7);
      end
      wb_write(32'h3C, 32'h1, 4'hF);
      exp_q.push_back(32'h1);
      wb_read(32'h3C, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL match_beats_w1c got=%h required=%h", rd, e);
      end
      wb_write(32'h30, 32'h0, 4'hF);
      wb_write(32'h3C, 32'h1, 4'hF);
      exp_q.push_back(32'h0);
      wb_read(32'h3C, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL w1c_clear got=%h required=%h", rd, e);
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] rd, e;
      wb_write(32'h00, 32'h1, 4'hF);
      wb_write(32'h10, 32'h9, 4'hF);
      repeat (8) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (count !== '0 || irq !== 1'b0 || ack !== 1'b0) begin
         failures++;
         $display("FAIL midrun_reset count=%h irq=%b ack=%b, required 0", count, irq, ack);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(32'h0);
      wb_read(32'h18, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL midrun_limit_cleared got=%h required=%h", rd, e);
      end
   endtask

`ifdef TIMER_PRESCALER_EN
   task automatic test_prescaler();
      logic [31:0] rd, e, prev;
      int last, n;
      wb_write(32'h80, 32'd3, 4'hF);
      exp_q.push_back(32'd3);
      wb_read(32'h80, rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL presc_read got=%h required=%h", rd, e);
      end
      wb_write(32'h08, 32'hFFFF, 4'hF);
      wb_write(32'h00, 32'h1, 4'hF);
      prev = get_cnt(0);
      last = -1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (get_cnt(0) != prev) begin
            if (last >= 0) begin
               checks++;
               if (i - last !== 4) begin
                  failures++;
                  $display("FAIL presc_interval got=%0d required=4", i - last);
               end
            end
            last = i;
            n++;
            prev = get_cnt(0);
         end
      end
      checks++;
      if (n < 5) begin
         failures++;
         $display("FAIL presc_increments got=%0d required>=5", n);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (count !== '0) begin
         failures++;
         $display("FAIL presc_reset count=%h required 0", count);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      sel = 4'h0; adr = 32'd0; wdat = 32'd0;
      test_reset();
      test_periodic_up();
      test_oneshot_down();
      test_byte_lanes();
      test_write_priority();
      test_w1c_race();
      test_reset_midrun();
`ifdef TIMER_PRESCALER_EN
      test_prescaler();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
